mmio_io_ctrl: RTL and testbench
===============================

Name: mmio_io_ctrl

Overview:
- Parametrised memory-mapped IO controller; replaces the fixed LED/seven-segment write-only decode in the SoC top.
- Sits on the CPU data bus behind the IO region select.
- Provides readable LED and segment registers, per-digit hex-decode mode, debounced button inputs, and a prescaled timer with compare-match interrupt.

Parameters:
- NUM_LEDS, 4, LED output count (1..32)
- NUM_SEGS, 2, seven-segment digit count (1..8)
- NUM_BTNS, 1, button input count (1..32)
- DEBOUNCE_CYCLES, 16'd50000, consecutive stable cycles before a button change is accepted (>=2)
- PRESCALE, 16'd12000, clk cycles per timer tick (>=1)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sel  in  1  IO region selected (qualifies rstrb and wmask)
- addr  in  4  word offset within IO region
- rstrb  in  1  read strobe
- wdata  in  32  write data
- wmask  in  4  byte write enables; any bit set = write
- rdata  out  32  registered read data
- btn_in  in  NUM_BTNS  raw asynchronous buttons, active-high
- leds  out  NUM_LEDS  LED drive
- seg  out  7*NUM_SEGS  segments, active-low, digit i at [7i+6:7i], order A..G MSB..LSB
- irq  out  1  timer interrupt, level

Behaviour:
- Reset (async assert, sync release to clk): leds=0, all seg bits=1 (blank), rdata=0, timer count=0, CMP=32'hFFFFFFFF, STATUS=0, irq=0, debounced buttons=0, prescaler=0.
- Register map (word offsets):
  - 0 LEDS: RW, bits [NUM_LEDS-1:0].
  - 1 BTNS: RO, debounced state.
  - 2 COUNT: RO.
  - 3 CMP: RW, per-byte wmask.
  - 4 STATUS: bit0 MATCH (sticky, write-1-clear), bit1 IE (RW).
  - 8+i SEG[i]: RW, bits [6:0] raw pattern, bit7 HEX mode.
- Registers other than CMP update only when wmask[0]=1.
- Writes to RO or unmapped offsets, and SEG offsets i>=NUM_SEGS, are ignored.
- Reads:
  - On sel&rstrb, rdata <= register value, zero-extended; valid the following cycle.
  - rdata holds otherwise.
  - Unmapped offsets return 0.
  - SEG[i] reads return the stored bit7 and [6:0], not the decoded output.
- Write and read of the same register in one cycle: rdata returns the old value.
- Segment output: HEX=0 drives bits [6:0] directly. HEX=1 drives the active-low hex decode of bits [3:0] (0-9, A-F; e.g. 0 -> 7'b0000001, 8 -> 7'b0000000, F -> 7'b0111000). Output is combinational from the register.
- Debounce, per button:
  - 2-FF synchroniser, then a stable counter.
  - While the synchronised value differs from the debounced value, the counter increments; any return to equality resets it to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced value takes the new level and the counter clears.
  - Latency from a clean edge = 2 + DEBOUNCE_CYCLES cycles.
- Timer:
  - Prescaler counts 0..PRESCALE-1; tick asserted on its terminal cycle.
  - On tick, COUNT <= COUNT+1, wrapping 32'hFFFFFFFF -> 0.
  - If the incremented value == CMP, MATCH <= 1.
  - A MATCH set and a W1C of MATCH in the same cycle: set wins.
  - COUNT is not writable; only reset clears it.
- irq = MATCH & IE, registered (one cycle after MATCH/IE change).
- Reset asserted mid-debounce or mid-prescale discards the partial count.

Decomposition:
- Package io_ctrl_pkg:
  - Register offset constants: OFF_LEDS, OFF_BTNS, OFF_COUNT, OFF_CMP, OFF_STATUS, OFF_SEG_BASE.
  - STATUS bit indices.
  - hex_to_seg function (4-bit -> active-low 7-bit).
- Sub-module io_debounce: one instance per button via generate. Ports clk, reset_n, din, dout; parameter DEBOUNCE_CYCLES.

Test Plan:
- Reset and readback: after reset, read offsets 0,3,4,8 -> 0, FFFFFFFF, 0, 0; seg all 1s; leds=0; irq=0.
- LEDs and segments:
  - Write LEDS=32'h5 with wmask=4'hF -> leds=4'b0101; read back 5.
  - Write with wmask=0 -> no change.
  - Write SEG[1]=32'h8A -> seg[13:7]=7'b0001000; SEG[0]=32'h7F (raw) -> seg[6:0]=7'h7F.
- Debounce (DEBOUNCE_CYCLES=4):
  - btn_in 0->1 for 3 cycles then back to 0 -> BTNS stays 0.
  - Held 1 -> BTNS reads 1 exactly 6 cycles after the edge.
- Timer match (PRESCALE=3, CMP=5):
  - MATCH set at the 15th cycle after reset release.
  - With IE=1, irq rises one cycle later.
  - W1C STATUS=32'h3 -> MATCH clears, irq falls next cycle, IE stays 1.
- Timer edges:
  - W1C on the same cycle as a match tick -> MATCH remains 1.
  - COUNT wraps at 32'hFFFFFFFF with CMP=0: wrap tick sets MATCH.
- Async reset: assert reset_n=0 mid-debounce and mid-prescale, between clock edges -> outputs take reset values immediately; counts restart from 0 after release.

Source files
------------

// File: rtl/io_ctrl_pkg.sv
// Shared constants and helpers for the memory-mapped IO controller.
// Contents: register word offsets, STATUS bit positions, and the
// active-low hex-to-seven-segment decoder (segment order A..G, MSB..LSB).
package io_ctrl_pkg;

  localparam logic [3:0] OFF_LEDS     = 4'd0;
  localparam logic [3:0] OFF_BTNS     = 4'd1;
  localparam logic [3:0] OFF_COUNT    = 4'd2;
  localparam logic [3:0] OFF_CMP      = 4'd3;
  localparam logic [3:0] OFF_STATUS   = 4'd4;
  localparam logic [3:0] OFF_SEG_BASE = 4'd8;

  localparam int unsigned STATUS_MATCH = 0;
  localparam int unsigned STATUS_IE    = 1;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// Single-button debouncer: 2-FF synchroniser followed by a stable counter.
// Ports: clk, reset_n (async active-low), din (raw button), dout (debounced).
// A new level is accepted after DEBOUNCE_CYCLES consecutive cycles of the
// synchronised input differing from dout; any agreement restarts the count.
module io_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  logic        sync1, sync2;
  logic [15:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      dout  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == dout) begin
        cnt <= '0;
      end else if (cnt == DEBOUNCE_CYCLES - 16'd1) begin
        dout <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped IO controller: LED and seven-segment registers, debounced
// buttons, and a prescaled 32-bit timer with compare-match interrupt.
// Ports: clk, reset_n (async active-low); bus side sel/addr/rstrb/wdata/wmask
// with registered rdata; btn_in raw buttons; leds, seg (active-low, digit i
// at [7i+6:7i]) and irq (level, registered MATCH & IE).
module mmio_io_ctrl
  import io_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LEDS        = 4,
  parameter int unsigned NUM_SEGS        = 2,
  parameter int unsigned NUM_BTNS        = 1,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [15:0] PRESCALE        = 16'd12000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sel,
  input  logic [3:0]            addr,
  input  logic                  rstrb,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wmask,
  output logic [31:0]           rdata,
  input  logic [NUM_BTNS-1:0]   btn_in,
  output logic [NUM_LEDS-1:0]   leds,
  output logic [7*NUM_SEGS-1:0] seg,
  output logic                  irq
);

  logic [NUM_LEDS-1:0] leds_q;
  logic [7:0]          seg_q [NUM_SEGS];
  logic [NUM_SEGS-1:0] seg_blank;
  logic [31:0]         cmp_q;
  logic [31:0]         count_q;
  logic [15:0]         presc_q;
  logic                match_q;
  logic                ie_q;
  logic [NUM_BTNS-1:0] btn_db;

  logic        wr_lo;
  logic        rd_en;
  logic        tick;
  logic [31:0] count_inc;
  logic        set_match;
  logic [31:0] rd_val;

  assign wr_lo     = sel & wmask[0];
  assign rd_en     = sel & rstrb;
  assign tick      = (presc_q == PRESCALE - 16'd1);
  assign count_inc = count_q + 32'd1;
  assign set_match = tick && (count_inc == cmp_q);

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (btn_in[g]),
      .dout    (btn_db[g])
    );
  end

  // Stored SEG values reset to 0 so reads return 0, but a raw 0 pattern
  // would light every segment; a per-digit blank flag keeps the digit dark
  // until its register is first written.
  for (genvar g = 0; g < NUM_SEGS; g++) begin : g_seg
    assign seg[7*g +: 7] = seg_blank[g]  ? 7'h7F :
                           seg_q[g][7]   ? hex_to_seg(seg_q[g][3:0]) :
                                           seg_q[g][6:0];
  end

  assign leds = leds_q;

  always_comb begin
    rd_val = '0;
    case (addr)
      OFF_LEDS:   rd_val[NUM_LEDS-1:0] = leds_q;
      OFF_BTNS:   rd_val[NUM_BTNS-1:0] = btn_db;
      OFF_COUNT:  rd_val = count_q;
      OFF_CMP:    rd_val = cmp_q;
      OFF_STATUS: begin
        rd_val[STATUS_MATCH] = match_q;
        rd_val[STATUS_IE]    = ie_q;
      end
      default: begin
        for (int unsigned i = 0; i < NUM_SEGS; i++)
          if (addr == OFF_SEG_BASE + 4'(i)) rd_val[7:0] = seg_q[i];
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      leds_q    <= '0;
      seg_blank <= '1;
      for (int unsigned i = 0; i < NUM_SEGS; i++) seg_q[i] <= '0;
      cmp_q     <= '1;
      count_q   <= '0;
      presc_q   <= '0;
      match_q   <= 1'b0;
      ie_q      <= 1'b0;
      irq       <= 1'b0;
      rdata     <= '0;
    end else begin
      if (rd_en) rdata <= rd_val;

      if (wr_lo && addr == OFF_LEDS) leds_q <= wdata[NUM_LEDS-1:0];

      for (int unsigned i = 0; i < NUM_SEGS; i++) begin
        if (wr_lo && addr == OFF_SEG_BASE + 4'(i)) begin
          seg_q[i]     <= wdata[7:0];
          seg_blank[i] <= 1'b0;
        end
      end

      for (int unsigned b = 0; b < 4; b++)
        if (sel && wmask[b] && addr == OFF_CMP) cmp_q[8*b +: 8] <= wdata[8*b +: 8];

      presc_q <= tick ? '0 : presc_q + 16'd1;
      if (tick) count_q <= count_inc;

      if (wr_lo && addr == OFF_STATUS) ie_q <= wdata[STATUS_IE];

      // A match tick takes priority over a same-cycle write-1-clear.
      if (set_match)
        match_q <= 1'b1;
      else if (wr_lo && addr == OFF_STATUS && wdata[STATUS_MATCH])
        match_q <= 1'b0;

      irq <= match_q & ie_q;
    end
  end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
module tb_mmio_io_ctrl;

  localparam int NL  = 4;
  localparam int NS  = 2;
  localparam int NB  = 2;
  localparam int DEB = 4;
  localparam int PRE = 3;
  localparam logic [31:0] LED_MASK = (32'd1 << NL) - 32'd1;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            sel = 1'b0;
  logic [3:0]      addr = '0;
  logic            rstrb = 1'b0;
  logic [31:0]     wdata = '0;
  logic [3:0]      wmask = '0;
  logic [31:0]     rdata;
  logic [NB-1:0]   btn_in = '0;
  logic [NL-1:0]   leds;
  logic [7*NS-1:0] seg;
  logic            irq;

  always #5 clk = ~clk;

  mmio_io_ctrl #(
    .NUM_LEDS(NL), .NUM_SEGS(NS), .NUM_BTNS(NB),
    .DEBOUNCE_CYCLES(16'd4), .PRESCALE(16'd3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sel(sel), .addr(addr), .rstrb(rstrb),
    .wdata(wdata), .wmask(wmask), .rdata(rdata), .btn_in(btn_in),
    .leds(leds), .seg(seg), .irq(irq)
  );

  int checks = 0;
  int errors = 0;

  logic [6:0] hex_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                               7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  // Reference model state
  logic [31:0]   m_leds, m_cmp, m_count;
  logic          m_match, m_ie, m_irq;
  logic [7:0]    m_seg [NS];
  logic          m_blank [NS];
  logic [NB-1:0] m_db;
  int unsigned   m_cyc;
  logic [NB-1:0] hist [$];
  logic [31:0]   exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] reg_value(input logic [3:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      4'd0: v = m_leds;
      4'd1: v = 32'(m_db);
      4'd2: v = m_count;
      4'd3: v = m_cmp;
      4'd4: v = {30'd0, m_ie, m_match};
      default: if (a >= 4'd8 && a < 4'(8 + NS)) v = {24'd0, m_seg[a - 4'd8]};
    endcase
    return v;
  endfunction

  function automatic logic [7*NS-1:0] exp_seg();
    logic [7*NS-1:0] v;
    for (int d = 0; d < NS; d++)
      v[7*d +: 7] = m_blank[d] ? 7'h7F : (m_seg[d][7] ? hex_tab[m_seg[d][3:0]] : m_seg[d][6:0]);
    return v;
  endfunction

  // Model: timer as cycle arithmetic, debounce as a sliding window over the
  // two-cycle-delayed input history.
  always @(posedge clk or negedge reset_n) begin
    logic [31:0]   cnt_n;
    logic          tick, set_m, clr_m, all_eq;
    logic [NB-1:0] db_n;
    int            hs;
    if (!reset_n) begin
      m_leds <= '0; m_cmp <= '1; m_count <= '0; m_match <= 1'b0; m_ie <= 1'b0;
      m_irq <= 1'b0; m_cyc <= 0; m_db <= '0;
      for (int i = 0; i < NS; i++) begin m_seg[i] <= '0; m_blank[i] <= 1'b1; end
      exp_q.delete();
      hist.delete();
      for (int i = 0; i < DEB + 2; i++) hist.push_back('0);
    end else begin
      if (sel && rstrb) exp_q.push_back(reg_value(addr));
      tick  = ((m_cyc + 1) % PRE) == 0;
      cnt_n = tick ? m_count + 32'd1 : m_count;
      set_m = tick && (cnt_n == m_cmp);
      m_cyc   <= m_cyc + 1;
      m_count <= cnt_n;
      m_irq   <= m_match & m_ie;
      clr_m = 1'b0;
      if (sel && wmask[0]) begin
        case (addr)
          4'd0: m_leds <= wdata & LED_MASK;
          4'd4: begin m_ie <= wdata[1]; clr_m = wdata[0]; end
          default: if (addr >= 4'd8 && addr < 4'(8 + NS)) begin
            m_seg[addr - 4'd8]   <= wdata[7:0];
            m_blank[addr - 4'd8] <= 1'b0;
          end
        endcase
      end
      if (sel && addr == 4'd3)
        for (int b = 0; b < 4; b++) if (wmask[b]) m_cmp[8*b +: 8] <= wdata[8*b +: 8];
      if (set_m) m_match <= 1'b1;
      else if (clr_m) m_match <= 1'b0;
      hist.push_back(btn_in);
      if (hist.size() > DEB + 2) void'(hist.pop_front());
      hs = hist.size();
      db_n = m_db;
      for (int b = 0; b < NB; b++) begin
        all_eq = 1'b1;
        for (int k = 2; k <= DEB + 1; k++) if (hist[hs-1-k][b] == m_db[b]) all_eq = 1'b0;
        if (all_eq) db_n[b] = ~m_db[b];
      end
      m_db <= db_n;
    end
  end

  // Monitor: pops the expected read value the cycle after a read and checks
  // the continuously visible outputs.
  always @(negedge clk) begin
    if (reset_n) begin
      if (exp_q.size() > 0) check("rdata", rdata, exp_q.pop_front());
      check("leds", 32'(leds), m_leds);
      check("seg", 32'(seg), 32'(exp_seg()));
      check("irq", 32'(irq), 32'(m_irq));
    end
  end

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    sel = 1'b1; addr = a; wdata = d; wmask = m; rstrb = 1'b0;
    @(negedge clk);
    sel = 1'b0; wmask = '0;
  endtask

  task automatic do_read(input logic [3:0] a);
    sel = 1'b1; addr = a; rstrb = 1'b1; wmask = '0;
    @(negedge clk);
    sel = 1'b0; rstrb = 1'b0;
  endtask

  task automatic do_rw(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    sel = 1'b1; addr = a; rstrb = 1'b1; wdata = d; wmask = m;
    @(negedge clk);
    sel = 1'b0; rstrb = 1'b0; wmask = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int k;
    int g;
    int op;
    int bi;
    logic [3:0]  a;
    logic [31:0] d;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset readback
    do_read(4'd0); do_read(4'd3); do_read(4'd4); do_read(4'd8);
    do_read(4'd1); do_read(4'd2);

    // LEDs and segments
    do_write(4'd0, 32'h5, 4'hF);
    check("leds_5", 32'(leds), 32'h5);
    do_read(4'd0);
    do_write(4'd0, 32'hA, 4'h0);
    do_read(4'd0);
    do_write(4'd0, 32'hA, 4'hE);
    do_read(4'd0);
    do_write(4'd9, 32'h8A, 4'h1);
    check("seg1_hexA", 32'(seg[13:7]), 32'h08);
    do_write(4'd8, 32'h7F, 4'hF);
    do_read(4'd8); do_read(4'd9);
    do_write(4'd8, 32'h88, 4'h1);
    check("seg0_hex8", 32'(seg[6:0]), 32'h00);
    do_write(4'd8, 32'h00, 4'h1);

    // CMP byte masking, RO / unmapped writes, read-during-write
    do_write(4'd3, 32'h12345678, 4'b0101);
    do_read(4'd3);
    do_write(4'd1, 32'hFFFFFFFF, 4'hF);
    do_write(4'd2, 32'hFFFFFFFF, 4'hF);
    do_write(4'd5, 32'hFFFFFFFF, 4'hF);
    do_write(4'd10, 32'hFF, 4'hF);
    do_read(4'd1); do_read(4'd2); do_read(4'd5); do_read(4'd10);
    do_rw(4'd0, 32'h3, 4'hF);
    do_read(4'd0);

    // Debounce: 3-cycle glitch rejected, held level accepted
    btn_in[0] = 1'b1;
    repeat (3) do_read(4'd1);
    btn_in[0] = 1'b0;
    repeat (8) do_read(4'd1);
    btn_in[0] = 1'b1;
    repeat (10) do_read(4'd1);

    // Async reset mid-debounce / mid-prescale
    btn_in[1] = 1'b1;
    do_read(4'd1);
    do_read(4'd3);
    #2 reset_n = 1'b0;
    #1;
    check("rst_leds", 32'(leds), 32'h0);
    check("rst_seg", 32'(seg), (32'd1 << (7*NS)) - 32'd1);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Timer match with CMP=5, irq latency counted from release
    do_write(4'd3, 32'd5, 4'hF);
    do_write(4'd4, 32'h2, 4'h1);
    k = 2;
    while (!irq && k < 40) begin
      do_read(4'd1);
      k++;
    end
    check("irq_latency", k, 16);
    do_write(4'd4, 32'h3, 4'h1);
    do_read(4'd4);
    do_write(4'd3, 32'd10, 4'hF);

    // W1C in the same cycle as the tick that matches CMP=10
    g = 0;
    while (m_cyc != 29 && g < 100) begin
      @(negedge clk);
      g++;
    end
    do_write(4'd4, 32'h3, 4'h1);
    do_read(4'd4);
    do_read(4'd2);

    // Randomised traffic
    repeat (3000) begin
      if ($urandom_range(0, 5) == 0) begin
        bi = $urandom_range(0, NB - 1);
        btn_in[bi] = ~btn_in[bi];
      end
      op = $urandom_range(0, 9);
      a  = 4'($urandom_range(0, 15));
      d  = $urandom;
      if (op < 4) begin
        do_read(a);
      end else if (op < 7) begin
        if (a == 4'd3) d = ($urandom_range(0, 3) == 0) ? 32'd0 : m_count + 32'($urandom_range(1, 6));
        do_write(a, d, 4'($urandom_range(0, 15)));
      end else if (op == 7) begin
        sel = 1'b0; rstrb = 1'b1; wmask = '1; addr = a; wdata = d;
        @(negedge clk);
        rstrb = 1'b0; wmask = '0;
      end else if (op == 8) begin
        do_rw(a, d, 4'hF);
      end else begin
        @(negedge clk);
      end
    end
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
